// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: word width,
// default bit period and the receiver FSM state type.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS    = 8;
   localparam int unsigned UART_CLKS_PER_BIT = 105;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
// The reset value lets idle-high lines come out of reset already idle.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: start-bit search, mid-bit sampling, stop check,
// one-entry hold register with valid/ready, framing-error and overrun pulses.
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rx,
   output logic [UART_DATA_BITS-1:0] rx_data,
   output logic                      rx_valid,
   input  logic                      rx_ready,
   output logic                      frame_err,
   output logic                      overrun
);

   localparam int unsigned HALF = CLKS_PER_BIT / 2;
   localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

   logic                      rx_s;
   rx_state_t                 state;
   logic [CW-1:0]             cyc_cnt;
   logic [2:0]                bit_cnt;
   logic [UART_DATA_BITS-1:0] shreg;
   logic                      done_good;
   logic                      done_bad;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cyc_cnt   <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         done_good <= 1'b0;
         done_bad  <= 1'b0;
      end else begin
         done_good <= 1'b0;
         done_bad  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!rx_s) begin
                  state   <= ST_START;
                  cyc_cnt <= '0;
                  bit_cnt <= '0;
               end
            end
            ST_START: begin
               if (cyc_cnt == CNT_HALF) begin
                  cyc_cnt <= '0;
                  state   <= rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  cyc_cnt <= cyc_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (cyc_cnt == CNT_LAST) begin
                  cyc_cnt        <= '0;
                  shreg[bit_cnt] <= rx_s;
                  if (bit_cnt == 3'd7) begin
                     state <= ST_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + 1'b1;
               end
            end
            ST_STOP: begin
               if (cyc_cnt == CNT_LAST) begin
                  cyc_cnt <= '0;
                  if (rx_s) begin
                     done_good <= 1'b1;
                     state     <= ST_IDLE;
                  end else begin
                     done_bad <= 1'b1;
                     state    <= ST_BREAK;
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + 1'b1;
               end
            end
            ST_BREAK: begin
               if (rx_s) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Completion flags land one edge after the stop sample, so a drain and a
   // load coinciding on that edge keep rx_valid high with the new byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= done_bad;
         overrun   <= 1'b0;
         if (done_good) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= shreg;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

UART receiver converting the serial `rx` line into 8-bit bytes for the CPU side of the design. It is the counterpart of the design's UART transmitter: same bit period, 8N1 framing, LSB first, line idle high. It synchronises the line, finds start bits, samples each bit at mid-period and checks the stop bit. Received bytes sit in a one-entry hold register with a valid/ready handshake, plus framing-error and overrun reporting.

## Interface
- `CLKS_PER_BIT`, default 105: clock cycles per bit; must equal the transmitter's bit period; legal range ≥ 8.
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx` in 1: serial line, asynchronous to `clk`, idle high.
- `rx_data` out 8: last accepted byte; valid while `rx_valid`=1.
- `rx_valid` out 1: hold register full.
- `rx_ready` in 1: consumer accepts byte when `rx_valid && rx_ready` at a clock edge.
- `frame_err` out 1: one-cycle pulse; stop bit sampled 0.
- `overrun` out 1: one-cycle pulse; frame completed while hold register full and not being drained.

## Operation
- `rx` passes through a 2-flop synchroniser; the synchroniser resets to 1. All decisions use its output `rx_s`.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: `rx_s`=0 → START, bit counter cleared, cycle counter cleared.
  - START: at cycle count H−1 (H = CLKS_PER_BIT/2, integer division), sample `rx_s`. 0 → DATA with counters cleared. 1 → false start → IDLE, no output.
  - DATA: every CLKS_PER_BIT cycles, sample `rx_s` into shift register bit[k], k = 0..7, LSB first. After bit 7 → STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rx_s`.
    - 1 → frame good → IDLE.
    - 0 → `frame_err` pulse, byte discarded → BREAK.
  - BREAK: wait for `rx_s`=1 → IDLE. No start detection while in BREAK.
- Good frame, hold register handling:
  - Empty, or draining this same cycle → load `rx_data`, `rx_valid`=1.
  - Full and `rx_ready`=0 → new byte dropped, old byte kept, `overrun` pulse.
- `rx_valid` clears on the edge after the handshake, unless a new byte loads on that same edge, in which case it stays 1.
- Reset mid-frame (any state) → all outputs and state return to reset values immediately. A partially received frame is lost. The next falling edge after release starts a fresh frame.

## Timing
- Reset values:
  - `rx_data`=8'h00, `rx_valid`=0, `frame_err`=0, `overrun`=0.
  - FSM=IDLE, synchroniser flops=1, counters=0.
- Let t0 be the first edge at which `rx_s`=0 in IDLE. This is 2 edges after the pin falls.
- Sample points:
  - Start-bit check at t0+H.
  - Data bit k at t0+H+(k+1)·CLKS_PER_BIT.
  - Stop bit at t0+H+9·CLKS_PER_BIT.
- `rx_valid`, `frame_err` and `overrun` update on the edge following the stop sample.
- Earliest next start detection: the edge after the stop sample. Back-to-back frames are therefore supported.
- Counters are sized to hold CLKS_PER_BIT−1; the bit counter is 3 bits plus a done condition, with no wrap into bit 8.

## Structure
- Shared package `uart_pkg`:
  - FSM state typedef.
  - `UART_DATA_BITS`=8.
  - Default bit-period constant, shared with the transmitter.
- Sub-module `sync_2ff`: parameterised reset value, 1-bit; reusable elsewhere in the design.
- Top holds the FSM, counters, shift register and hold register.

## Test plan
- CLKS_PER_BIT=16, send 8'hA5 with stop=1, `rx_ready`=0 → `rx_valid`=1, `rx_data`=8'hA5 at t0+8+144+1. `frame_err`=0, `overrun`=0.
- Drive `rx` low for 5 cycles then high → no `rx_valid`, no `frame_err`; FSM back in IDLE. A following 8'h3C is received correctly.
- Send 8'h3C with stop bit 0, line held low 40 more cycles → one `frame_err` pulse, `rx_valid` stays 0. No start detected until line high. Next frame 8'h81 received.
- Two frames 8'h11 then 8'h22, `rx_ready`=0 → `rx_data`=8'h11 held, one `overrun` pulse at second frame end. Then `rx_ready`=1 for one cycle → `rx_valid` clears next edge.
- 8'h11 pending, assert `rx_ready` exactly on the edge the 8'h22 frame completes → `rx_data`=8'h22, `rx_valid` stays 1, no `overrun`.
- Assert `rst_n`=0 during DATA bit 4 of 8'hFF → outputs zero asynchronously. After release, send 8'h5A → received as 8'h5A, no errors.
